// File: rtl/buf_rd_sequencer.sv
// ---------------------------------------------------------------------------
// buf_rd_sequencer
//
// Read-address sequencer for the on-chip weight/activation buffers that feed
// the systolic array. A start pulse (taken only while idle) captures a base
// address, a sweep length, a repeat count and a sweep direction. The block
// then issues one read per cycle in which the consumer is ready. It sweeps
// up or down from the base, repeats the sweep rep_i+1 times, waits out the
// buffer read latency and then pulses done_o.
//
// Ports
//   clk        system clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   start_i    start request, looked at only while idle
//   base_i     first address of every pass
//   len_i      addresses per pass (0 = empty job, no reads)
//   rep_i      extra passes (total passes = rep_i + 1)
//   mode_i     1 = count up, 0 = count down
//   ready_i    consumer can take a read this cycle
//   rd_en_o    read strobe, one address issued per asserted cycle
//   rd_addr_o  address of the current read
//   last_o     final read of the final pass
//   busy_o     high whenever the sequencer is not idle
//   done_o     one-cycle completion pulse
// ---------------------------------------------------------------------------
module buf_rd_sequencer #(
  parameter int ADDR_BIT = 8,
  parameter int LEN_BIT  = 8,
  parameter int REP_BIT  = 4,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_BIT-1:0] base_i,
  input  logic [LEN_BIT-1:0]  len_i,
  input  logic [REP_BIT-1:0]  rep_i,
  input  logic                mode_i,
  input  logic                ready_i,
  output logic                rd_en_o,
  output logic [ADDR_BIT-1:0] rd_addr_o,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The drain counter counts down to zero, so it is loaded with RD_LAT-1 to
  // spend exactly RD_LAT cycles in DRAIN. With RD_LAT==0 DRAIN is skipped.
  localparam logic [2:0] LAT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_t              state_q, state_d;
  logic [ADDR_BIT-1:0] addr_q,  addr_d;
  logic [LEN_BIT-1:0]  elem_q,  elem_d;
  logic [REP_BIT-1:0]  pass_q,  pass_d;
  logic [ADDR_BIT-1:0] base_q,  base_d;
  logic [LEN_BIT-1:0]  len_q,   len_d;
  logic                mode_q,  mode_d;
  logic [2:0]          lat_q,   lat_d;
  logic                busy_q,  busy_d;

  logic                rd_en;
  logic                last;
  logic [ADDR_BIT-1:0] addr_step;

  // Next sequential address; wraps modulo 2^ADDR_BIT in either direction.
  assign addr_step = mode_q ? (addr_q + ADDR_BIT'(1)) : (addr_q - ADDR_BIT'(1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    elem_d  = elem_q;
    pass_d  = pass_q;
    base_d  = base_q;
    len_d   = len_q;
    mode_d  = mode_q;
    lat_d   = lat_q;
    rd_en   = 1'b0;
    last    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d = base_i;
          len_d  = len_i;
          mode_d = mode_i;
          addr_d = base_i;
          // Underflow for len_i==0 is harmless: RUN is never entered.
          elem_d = len_i - LEN_BIT'(1);
          pass_d = rep_i;
          lat_d  = LAT_INIT;
          state_d = (len_i != '0) ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN: begin
        rd_en = ready_i;
        if (ready_i) begin
          if (elem_q == '0) begin
            if (pass_q != '0) begin
              // Next pass starts on the very next cycle: no bubble.
              addr_d = base_q;
              elem_d = len_q - LEN_BIT'(1);
              pass_d = pass_q - REP_BIT'(1);
            end else begin
              last   = 1'b1;
              addr_d = addr_step;
              lat_d  = LAT_INIT;
              state_d = (RD_LAT > 0) ? ST_DRAIN : ST_DONE;
            end
          end else begin
            addr_d = addr_step;
            elem_d = elem_q - LEN_BIT'(1);
          end
        end
      end

      ST_DRAIN: begin
        // Covers the buffer read latency of the final read; ready_i ignored.
        if (lat_q == 3'd0) begin
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      elem_q  <= '0;
      pass_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      lat_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      elem_q  <= elem_d;
      pass_q  <= pass_d;
      base_q  <= base_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
    end
  end

  assign rd_en_o   = rd_en;
  assign rd_addr_o = addr_q;
  assign last_o    = last;
  assign busy_o    = busy_q;
  assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_buf_rd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_buf_rd_sequencer
//
// Self-checking bench for buf_rd_sequencer (default parameters, RD_LAT=1).
// Directed jobs come from a table of {inputs, expected results}. Random jobs
// are checked against a job-level reference: the expected address list is
// built from base/len/rep/mode, and the expected timing follows from the
// bench's own ready pattern.
// ---------------------------------------------------------------------------
module tb_buf_rd_sequencer;

  localparam int ADDR_BIT = 8;
  localparam int LEN_BIT  = 8;
  localparam int REP_BIT  = 4;
  localparam int RD_LAT   = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start_i;
  logic [ADDR_BIT-1:0] base_i;
  logic [LEN_BIT-1:0]  len_i;
  logic [REP_BIT-1:0]  rep_i;
  logic                mode_i;
  logic                ready_i;
  logic                rd_en_o;
  logic [ADDR_BIT-1:0] rd_addr_o;
  logic                last_o;
  logic                busy_o;
  logic                done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buf_rd_sequencer #(
    .ADDR_BIT(ADDR_BIT),
    .LEN_BIT (LEN_BIT),
    .REP_BIT (REP_BIT),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .base_i   (base_i),
    .len_i    (len_i),
    .rep_i    (rep_i),
    .mode_i   (mode_i),
    .ready_i  (ready_i),
    .rd_en_o  (rd_en_o),
    .rd_addr_o(rd_addr_o),
    .last_o   (last_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    logic [3:0] rep;
    logic       mode;
    int         stall_at;
    int         stall_n;
    bit         start_mid;
    int         exp_reads;
    int         exp_last;
    int         exp_done_off;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one job and checks every cycle against the reference. Returns the
  // observed read count, the address seen with last_o, the done_o offset
  // (from the first read, or from the accepting edge for an empty job) and
  // the number of done_o pulses.
  task automatic run_job(input logic [7:0] base, input logic [7:0] len,
                         input logic [3:0] rep, input logic mode,
                         input int stall_at, input int stall_n,
                         input bit rand_ready, input bit start_mid,
                         output int n_reads, output int last_addr,
                         output int done_off, output int n_done);
    logic [7:0] exp_q[$];
    logic [7:0] a;
    int total, model_reads, done_idx, first_idx, stall_left, idx;
    bit rdy, exp_rd;

    total = int'(len) * (int'(rep) + 1);
    for (int p = 0; p <= int'(rep); p++) begin
      for (int i = 0; i < int'(len); i++) begin
        a = mode ? (base + 8'(i)) : (base - 8'(i));
        exp_q.push_back(a);
      end
    end
    n_reads = 0; last_addr = -1; done_off = -1; n_done = 0;
    model_reads = 0; first_idx = -1; stall_left = stall_n;
    // An empty job goes straight to DONE on the cycle after acceptance.
    done_idx = (total == 0) ? 1 : -1;

    @(negedge clk);
    start_i = 1'b1; base_i = base; len_i = len; rep_i = rep; mode_i = mode;
    ready_i = 1'b1;
    #1;
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_rd_en", 32'(rd_en_o), 32'd0);

    for (idx = 1; idx < 3000; idx++) begin
      @(negedge clk);
      base_i = 8'($urandom); len_i = 8'($urandom);
      rep_i = 4'($urandom); mode_i = 1'($urandom);
      exp_rd = 1'b0;
      if (model_reads < total) begin
        if (stall_left > 0 && model_reads == stall_at) begin
          rdy = 1'b0;
          stall_left--;
        end else if (rand_ready && idx < 1000) begin
          rdy = ($urandom_range(0, 3) != 0);
        end else begin
          rdy = 1'b1;
        end
        exp_rd = rdy;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      ready_i = rdy;
      start_i = start_mid && (idx == 2 || idx == done_idx);
      #1;
      chk("rd_en", 32'(rd_en_o), 32'(exp_rd));
      if (model_reads < total) chk("rd_addr", 32'(rd_addr_o), 32'(exp_q[model_reads]));
      chk("last", 32'(last_o), 32'(exp_rd && model_reads == total - 1));
      chk("done", 32'(done_o), 32'(idx == done_idx));
      chk("busy", 32'(busy_o), 32'(done_idx < 0 || idx <= done_idx));
      if (rd_en_o) begin
        n_reads++;
        if (first_idx < 0) first_idx = idx;
        if (last_o) last_addr = int'(rd_addr_o);
      end
      if (done_o) begin
        n_done++;
        done_off = (first_idx < 0) ? idx : idx - first_idx;
      end
      if (exp_rd) begin
        model_reads++;
        if (model_reads == total) done_idx = idx + RD_LAT + 1;
      end
      if (done_idx >= 0 && idx > done_idx) break;
    end
    start_i = 1'b0;
    chk("job_timeout", 32'(done_idx >= 0 && idx > done_idx), 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    int n_reads, last_addr, done_off, n_done;
    logic [7:0] rb, rl;
    logic [3:0] rr;
    logic       rm;

    // base  len  rep mode stall_at n start_mid reads last   done_off
    vecs[0] = '{8'h10, 8'd4, 4'd0, 1'b1, -1, 0, 1'b0, 4, 'h13, 5};  // up sweep
    vecs[1] = '{8'h01, 8'd3, 4'd0, 1'b0, -1, 0, 1'b0, 3, 'hFF, 4};  // down, wrap
    vecs[2] = '{8'h20, 8'd2, 4'd2, 1'b1, -1, 0, 1'b0, 6, 'h21, 7};  // repeats
    vecs[3] = '{8'h10, 8'd4, 4'd0, 1'b1,  2, 2, 1'b0, 4, 'h13, 7};  // back-pressure
    vecs[4] = '{8'h30, 8'd4, 4'd0, 1'b1, -1, 0, 1'b1, 4, 'h33, 5};  // ignored starts
    vecs[5] = '{8'hFE, 8'd3, 4'd1, 1'b1, -1, 0, 1'b0, 6, 'h00, 7};  // up wrap, 2 passes
    vecs[6] = '{8'h55, 8'd0, 4'd3, 1'b1, -1, 0, 1'b0, 0, -1,   1};  // empty job

    rst_n = 1'b0; start_i = 1'b0; base_i = '0; len_i = '0; rep_i = '0;
    mode_i = 1'b0; ready_i = 1'b0;
    #23;
    chk("reset_outputs", 32'({rd_en_o, last_o, busy_o, done_o, rd_addr_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_job(vecs[v].base, vecs[v].len, vecs[v].rep, vecs[v].mode,
              vecs[v].stall_at, vecs[v].stall_n, 1'b0, vecs[v].start_mid,
              n_reads, last_addr, done_off, n_done);
      chk($sformatf("vec%0d_reads", v), 32'(n_reads), 32'(vecs[v].exp_reads));
      chk($sformatf("vec%0d_last_addr", v), 32'(last_addr), 32'(vecs[v].exp_last));
      chk($sformatf("vec%0d_done_off", v), 32'(done_off), 32'(vecs[v].exp_done_off));
      chk($sformatf("vec%0d_done_cnt", v), 32'(n_done), 32'd1);
      $display("vec %0d base=%02h len=%0d rep=%0d mode=%0d reads=%0d last=%0h done_off=%0d",
               v, vecs[v].base, vecs[v].len, vecs[v].rep, vecs[v].mode,
               n_reads, last_addr, done_off);
    end

    // Reset abort: len=8 job, reset after the second read.
    @(negedge clk);
    start_i = 1'b1; base_i = 8'h40; len_i = 8'd8; rep_i = 4'd0; mode_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("abort_rd1", 32'({rd_en_o, rd_addr_o}), 32'h140);
    @(negedge clk);
    #1;
    chk("abort_rd2", 32'({rd_en_o, rd_addr_o}), 32'h141);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({rd_en_o, last_o, busy_o, done_o, rd_addr_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", 32'({done_o, busy_o, rd_en_o}), 32'd0);
    end
    $display("reset abort checked");
    run_job(8'h80, 8'd3, 4'd0, 1'b0, -1, 0, 1'b0, 1'b0,
            n_reads, last_addr, done_off, n_done);
    chk("post_abort_reads", 32'(n_reads), 32'd3);
    chk("post_abort_last", 32'(last_addr), 32'h7E);
    chk("post_abort_done", 32'(n_done), 32'd1);
    $display("post-abort job reads=%0d last=%0h", n_reads, last_addr);

    // Random jobs with random back-pressure.
    for (int j = 0; j < 25; j++) begin
      rb = 8'($urandom); rl = 8'($urandom_range(0, 12));
      rr = 4'($urandom_range(0, 3)); rm = 1'($urandom);
      run_job(rb, rl, rr, rm, -1, 0, 1'b1, 1'($urandom),
              n_reads, last_addr, done_off, n_done);
      chk("rand_reads", 32'(n_reads), 32'(int'(rl) * (int'(rr) + 1)));
      chk("rand_done_cnt", 32'(n_done), 32'd1);
      $display("rand %0d base=%02h len=%0d rep=%0d mode=%0d reads=%0d",
               j, rb, rl, rr, rm, n_reads);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
